// File: rtl/rescaler_pkg.sv
// Shared width helpers and saturation bounds for the rescaler datapath and later filter blocks.
// Bounds are returned as wide vectors; callers slice them to their own width.
package rescaler_pkg;

  localparam int MAX_W = 128;

  // Largest signed value representable in w bits, in the low w bits of the result.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Most negative signed value in w bits, in the low w bits of the result.
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  // Unity gain for a gain word with frac fractional bits.
  function automatic logic [MAX_W-1:0] gain_one(input int frac);
    return MAX_W'(1) << frac;
  endfunction

  function automatic int prod_w(input int in_w, input int gain_w);
    return in_w + gain_w;
  endfunction

  // Sum width: aligned product plus one guard bit, never narrower than the offset plus one.
  function automatic int sum_w(input int in_w, input int gain_w, input int shift, input int out_w);
    int a;
    a = in_w + gain_w + shift + 1;
    return (a > out_w + 1) ? a : out_w + 1;
  endfunction

endpackage

// File: rtl/gain_offset_rescaler_sat_narrow.sv
// Combinational signed saturating narrower: clips an IN_W-bit signed value into OUT_W bits
// and flags when clipping happened.
module sat_narrow
  import rescaler_pkg::*;
#(
  parameter int IN_W  = 35,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             clip_o
);

  localparam logic [MAX_W-1:0] MAX_FULL = sat_max(OUT_W);
  localparam logic [MAX_W-1:0] MIN_FULL = sat_min(OUT_W);
  localparam logic [OUT_W-1:0] MAX_V    = MAX_FULL[OUT_W-1:0];
  localparam logic [OUT_W-1:0] MIN_V    = MIN_FULL[OUT_W-1:0];

  logic [IN_W-OUT_W:0] top_bits;
  logic                fits;

  // The value fits when every bit from the output sign bit upward equals the input sign.
  always_comb begin
    top_bits = din_i[IN_W-1:OUT_W-1];
    fits     = (&top_bits) | ~(|top_bits);
    clip_o   = ~fits;
    dout_o   = din_i[OUT_W-1:0];
    if (!fits) begin
      dout_o = din_i[IN_W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/gain_offset_rescaler.sv
// Three-stage gain/offset rescaler: IN_W signed sample -> OUT_W signed fixed point with
// runtime double-buffered gain/offset, saturation flag and sticky saturation latch.
module gain_offset_rescaler
  import rescaler_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int OUT_FRAC  = 16,
  parameter int GAIN_W    = 18,
  parameter int GAIN_FRAC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IN_W-1:0]   data_i,
  input  logic              valid_i,
  input  logic [GAIN_W-1:0] gain_i,
  input  logic [OUT_W-1:0]  offset_i,
  input  logic              cfg_load_i,
  input  logic              sat_clr_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              valid_o,
  output logic              sat_o,
  output logic              sat_sticky_o
);

  localparam int SHIFT  = OUT_FRAC - GAIN_FRAC;
  localparam int PROD_W = prod_w(IN_W, GAIN_W);
  localparam int SUM_W  = sum_w(IN_W, GAIN_W, SHIFT, OUT_W);
  localparam logic [MAX_W-1:0]  GAIN_ONE_FULL = gain_one(GAIN_FRAC);
  localparam logic [GAIN_W-1:0] GAIN_ONE      = GAIN_ONE_FULL[GAIN_W-1:0];

  // Valid semantics: no backpressure; a sample is taken on every edge where valid_i=1 and
  // valid_o pulses exactly three cycles later for each one, never otherwise.

  logic [GAIN_W-1:0] gain_act_q, gain_act_d;
  logic [OUT_W-1:0]  offset_act_q, offset_act_d;

  logic              s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]   s1_data_q, s1_data_d;
  logic [GAIN_W-1:0] s1_gain_q, s1_gain_d;
  logic [OUT_W-1:0]  s1_offset_q, s1_offset_d;

  logic              s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0] s2_prod_q, s2_prod_d;
  logic [OUT_W-1:0]  s2_offset_q, s2_offset_d;

  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sat_q, out_sat_d;
  logic              sticky_q, sticky_d;

  logic [PROD_W-1:0] mult_a, mult_b;
  logic [SUM_W-1:0]  prod_ext, offset_ext, sum;
  logic [OUT_W-1:0]  narrow_data;
  logic              narrow_clip;

  sat_narrow #(
    .IN_W  (SUM_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din_i  (sum),
    .dout_o (narrow_data),
    .clip_o (narrow_clip)
  );

  always_comb begin
    gain_act_d   = gain_act_q;
    offset_act_d = offset_act_q;
    if (cfg_load_i) begin
      gain_act_d   = gain_i;
      offset_act_d = offset_i;
    end

    // A sample arriving with cfg_load_i snapshots the freshly loaded pair.
    s1_valid_d  = valid_i;
    s1_data_d   = data_i;
    s1_gain_d   = gain_act_d;
    s1_offset_d = offset_act_d;

    mult_a      = {{(PROD_W-IN_W){s1_data_q[IN_W-1]}}, s1_data_q};
    mult_b      = {{(PROD_W-GAIN_W){s1_gain_q[GAIN_W-1]}}, s1_gain_q};
    s2_valid_d  = s1_valid_q;
    s2_prod_d   = mult_a * mult_b;
    s2_offset_d = s1_offset_q;

    prod_ext    = {{(SUM_W-PROD_W){s2_prod_q[PROD_W-1]}}, s2_prod_q} << SHIFT;
    offset_ext  = {{(SUM_W-OUT_W){s2_offset_q[OUT_W-1]}}, s2_offset_q};
    sum         = prod_ext + offset_ext;

    out_data_d  = narrow_data;
    out_valid_d = s2_valid_q;
    out_sat_d   = s2_valid_q & narrow_clip;

    // Saturation seen on either side of the clear edge wins over the clear.
    sticky_d    = out_sat_d | out_sat_q | (sticky_q & ~sat_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gain_act_q   <= GAIN_ONE;
      offset_act_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_gain_q    <= GAIN_ONE;
      s1_offset_q  <= '0;
      s2_valid_q   <= 1'b0;
      s2_prod_q    <= '0;
      s2_offset_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sat_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      gain_act_q   <= gain_act_d;
      offset_act_q <= offset_act_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_gain_q    <= s1_gain_d;
      s1_offset_q  <= s1_offset_d;
      s2_valid_q   <= s2_valid_d;
      s2_prod_q    <= s2_prod_d;
      s2_offset_q  <= s2_offset_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sat_q    <= out_sat_d;
      sticky_q     <= sticky_d;
    end
  end

  assign data_o       = out_data_q;
  assign valid_o      = out_valid_q;
  assign sat_o        = out_sat_q;
  assign sat_sticky_o = sticky_q;

endmodule

// File: tb/tb_gain_offset_rescaler.sv
// Bench for gain_offset_rescaler: directed legacy/offset/saturation/coefficient/sticky/reset
// steps plus a random stream, checked against an arithmetic reference model.
module tb_gain_offset_rescaler;

  localparam int IN_W      = 16;
  localparam int OUT_W     = 32;
  localparam int OUT_FRAC  = 16;
  localparam int GAIN_W    = 18;
  localparam int GAIN_FRAC = 16;
  localparam logic [GAIN_W-1:0] G_ONE = 18'h10000;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [IN_W-1:0]   data_i;
  logic              valid_i;
  logic [GAIN_W-1:0] gain_i;
  logic [OUT_W-1:0]  offset_i;
  logic              cfg_load_i;
  logic              sat_clr_i;
  logic [OUT_W-1:0]  data_o;
  logic              valid_o;
  logic              sat_o;
  logic              sat_sticky_o;

  always #5 clk_i = ~clk_i;

  gain_offset_rescaler #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .OUT_FRAC  (OUT_FRAC),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .gain_i       (gain_i),
    .offset_i     (offset_i),
    .cfg_load_i   (cfg_load_i),
    .sat_clr_i    (sat_clr_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .sat_o        (sat_o),
    .sat_sticky_o (sat_sticky_o)
  );

  // Expected results {sat, data} and the cycle each one must appear on.
  logic [OUT_W:0]    exp_q[$];
  int                due_q[$];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  logic [GAIN_W-1:0] m_gain   = G_ONE;
  logic [OUT_W-1:0]  m_off    = '0;
  logic              m_sticky = 1'b0;
  logic              m_prev_sat = 1'b0;

  function automatic logic [OUT_W:0] ref_model(logic [IN_W-1:0] x, logic [GAIN_W-1:0] g,
                                               logic [OUT_W-1:0] o);
    longint xs, gs, os, s, hi, lo;
    xs = longint'($signed(x));
    gs = longint'($signed(g));
    os = longint'($signed(o));
    s  = xs * gs * (longint'(1) << (OUT_FRAC - GAIN_FRAC)) + os;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (s > hi) return {1'b1, OUT_W'(hi)};
    if (s < lo) return {1'b1, OUT_W'(lo)};
    return {1'b0, OUT_W'(s)};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then check every output after the edge.
  task automatic step(logic rst, logic v, logic [IN_W-1:0] x, logic ld,
                      logic [GAIN_W-1:0] g, logic [OUT_W-1:0] o, logic clr);
    logic [OUT_W:0] e;
    logic           exp_v, exp_sat;
    rst_i = rst; valid_i = v; data_i = x; cfg_load_i = ld;
    gain_i = g; offset_i = o; sat_clr_i = clr;
    if (!rst) begin
      if (ld) begin
        m_gain = g;
        m_off  = o;
      end
      if (v) begin
        exp_q.push_back(ref_model(x, m_gain, m_off));
        due_q.push_back(cyc + 3);
      end
    end
    @(posedge clk_i);
    cyc++;
    #1;
    exp_v   = 1'b0;
    exp_sat = 1'b0;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_gain = G_ONE; m_off = '0; m_sticky = 1'b0; m_prev_sat = 1'b0;
      check("rst_data", 64'(data_o), 64'd0);
    end else begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        exp_v   = 1'b1;
        exp_sat = e[OUT_W];
        check("data", 64'(data_o), 64'(e[OUT_W-1:0]));
      end
      m_sticky   = exp_sat | m_prev_sat | (m_sticky & ~clr);
      m_prev_sat = exp_sat;
    end
    check("valid", 64'(valid_o), 64'(exp_v));
    check("sat", 64'(sat_o), 64'(exp_sat));
    check("sticky", 64'(sat_sticky_o), 64'(m_sticky));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic sample(logic [IN_W-1:0] x);
    step(1'b0, 1'b1, x, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load(logic [GAIN_W-1:0] g, logic [OUT_W-1:0] o);
    step(1'b0, 1'b0, '0, 1'b1, g, o, 1'b0);
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    idle(2);

    // Legacy conversion and three-cycle latency
    sample(16'h7FFF);
    idle(3);
    sample(16'hFFFF);
    idle(3);

    // Offset
    load(18'h10000, 32'h0000_8000);
    sample(16'h0003);
    idle(3);

    // Saturation high then low
    load(18'h1FFFF, 32'h0);
    sample(16'h7FFF);
    idle(3);
    load(18'h20000, 32'h0);
    sample(16'h7FFF);
    idle(3);

    // Coefficient timing: load -2.0 together with the fifth sample of a stream
    load(G_ONE, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) step(1'b0, 1'b1, 16'h0001, 1'b1, 18'h20000, 32'h0, 1'b0);
      else sample(16'h0001);
    end
    idle(3);

    // Sticky: clear while saturations keep arriving, then clear with none in flight
    load(18'h1FFFF, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h7FFF, 1'b0, '0, '0, i >= 3);
    idle(4);
    step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(2);

    // Random stream with occasional reloads and clears
    for (int i = 0; i < 300; i++) begin
      step(1'b0, $urandom_range(0, 3) != 0, IN_W'($urandom), $urandom_range(0, 15) == 0,
           GAIN_W'($urandom), ($urandom_range(0, 1) == 0) ? OUT_W'($urandom) : 32'h0,
           $urandom_range(0, 7) == 0);
    end
    idle(4);

    // Reset with two samples in flight; gain must return to 1.0
    load(18'h20000, 32'h0000_1234);
    sample(16'h0100);
    sample(16'h0200);
    step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    idle(5);
    sample(16'h0001);
    idle(4);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
